// File: rtl/uart_rx_fifo.sv
// 8N1 oversampling UART receiver feeding a first-word-fall-through receive FIFO,
// with sticky framing-error and overrun flags.
module uart_rx_fifo #(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd,
   input  logic                          rd_en,
   input  logic                          err_clr,
   output logic [7:0]                    data_out,
   output logic                          data_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overrun
);

   localparam int unsigned DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
   localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   logic rx_meta;
   logic rxs;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
      end
   end

   // Free-running 16x oversample divider
   logic [DW-1:0] div_cnt;
   logic          tick_c;

   assign tick_c = (div_cnt == DW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || tick_c) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Line must be seen high on a tick after reset before a start is accepted
   logic armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         armed <= 1'b0;
      end else if (tick_c && rxs) begin
         armed <= 1'b1;
      end
   end

   state_t     state;
   state_t     state_nxt;
   logic [3:0] s_cnt;
   logic [3:0] s_cnt_nxt;
   logic [3:0] cnt_inc;
   logic [2:0] bit_idx;
   logic [2:0] bit_idx_nxt;
   logic [7:0] shreg;
   logic [7:0] shreg_nxt;
   logic       smp7;
   logic       smp7_nxt;
   logic       smp8;
   logic       smp8_nxt;
   logic       maj_c;
   logic       push_c;
   logic       ferr_set_c;

   assign cnt_inc = s_cnt + 4'd1;
   assign maj_c   = (smp7 & smp8) | (smp7 & rxs) | (smp8 & rxs);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         s_cnt   <= 4'd0;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
         smp7    <= 1'b0;
         smp8    <= 1'b0;
      end else begin
         state   <= state_nxt;
         s_cnt   <= s_cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
         smp7    <= smp7_nxt;
         smp8    <= smp8_nxt;
      end
   end

   // Sample counter numbers ticks within a 16-tick bit cell; the start-detect tick is 0
   always_comb begin
      state_nxt   = state;
      s_cnt_nxt   = s_cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      smp7_nxt    = smp7;
      smp8_nxt    = smp8;
      push_c      = 1'b0;
      ferr_set_c  = 1'b0;

      if (tick_c) begin
         case (state)
            ST_IDLE: begin
               if (armed && !rxs) begin
                  state_nxt = ST_START;
                  s_cnt_nxt = 4'd0;
               end
            end
            ST_START: begin
               s_cnt_nxt = cnt_inc;
               if (cnt_inc == 4'd8 && rxs) begin
                  state_nxt = ST_IDLE;
               end else if (cnt_inc == 4'd0) begin
                  state_nxt   = ST_DATA;
                  bit_idx_nxt = 3'd0;
               end
            end
            ST_DATA: begin
               s_cnt_nxt = cnt_inc;
               if (cnt_inc == 4'd7) smp7_nxt = rxs;
               if (cnt_inc == 4'd8) smp8_nxt = rxs;
               if (cnt_inc == 4'd9) shreg_nxt = {maj_c, shreg[7:1]};
               if (cnt_inc == 4'd0) begin
                  if (bit_idx == 3'd7) begin
                     state_nxt = ST_STOP;
                  end else begin
                     bit_idx_nxt = bit_idx + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               s_cnt_nxt = cnt_inc;
               if (cnt_inc == 4'd7) smp7_nxt = rxs;
               if (cnt_inc == 4'd8) smp8_nxt = rxs;
               if (cnt_inc == 4'd9) begin
                  if (maj_c) begin
                     push_c    = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     ferr_set_c = 1'b1;
                     state_nxt  = ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (rxs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Receive FIFO: pointers carry one wrap bit beyond the address
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        empty_c;
   logic        full_c;
   logic        do_pop_c;
   logic        do_push_c;
   logic        ovr_set_c;

   assign empty_c   = (wptr == rptr);
   assign full_c    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign do_pop_c  = rd_en && !empty_c;
   assign do_push_c = push_c && (!full_c || do_pop_c);
   assign ovr_set_c = push_c && full_c && !do_pop_c;

   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem[wptr[AW-1:0]] <= shreg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push_c) wptr <= wptr + 1'b1;
         if (do_pop_c)  rptr <= rptr + 1'b1;
      end
   end

   // Sticky error flags; a new error outranks a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (ferr_set_c)   frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (ovr_set_c)    overrun <= 1'b1;
         else if (err_clr) overrun <= 1'b0;
      end
   end

   assign data_out   = mem[rptr[AW-1:0]];
   assign data_valid = !empty_c;
   assign fifo_count = wptr - rptr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; the clock is scaled so one oversample tick is
// four clocks and one bit is 64 clocks at the nominal 115200 baud.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int unsigned CLK_FREQ = 7372800;
   localparam int unsigned BAUD     = 115200;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned BIT_CLK  = 64;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       rxd     = 1'b1;
   logic       rd_en   = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic [4:0] fifo_count;
   logic       frame_err;
   logic       overrun;

   int checks   = 0;
   int failures = 0;

   uart_rx_fifo #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .rd_en      (rd_en),
      .err_clr    (err_clr),
      .data_out   (data_out),
      .data_valid (data_valid),
      .fifo_count (fifo_count),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One 8N1 frame, LSB first, with a selectable stop-bit level and a short idle gap
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (BIT_CLK) @(negedge clk);
      rxd = 1'b1;
      repeat (BIT_CLK / 4) @(negedge clk);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      @(negedge clk);
      check(tag, 32'(data_out), 32'(exp));
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      repeat (150000) @(posedge clk);
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;

      repeat (5) @(negedge clk);
      check("rst_valid",   32'(data_valid), 32'd0);
      check("rst_count",   32'(fifo_count), 32'd0);
      check("rst_ferr",    32'(frame_err),  32'd0);
      check("rst_overrun", 32'(overrun),    32'd0);
      rst = 1'b0;
      repeat (BIT_CLK) @(negedge clk);

      // Single byte then one pop
      send_byte(8'h55, 1'b1);
      @(negedge clk);
      check("single_valid", 32'(data_valid), 32'd1);
      check("single_data",  32'(data_out),   32'h55);
      check("single_count", 32'(fifo_count), 32'd1);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check("single_pop_valid", 32'(data_valid), 32'd0);
      check("single_pop_count", 32'(fifo_count), 32'd0);

      // Short low glitch must be rejected
      rxd = 1'b0;
      repeat (15) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      check("glitch_count", 32'(fifo_count), 32'd0);
      check("glitch_valid", 32'(data_valid), 32'd0);
      send_byte(8'hA3, 1'b1);
      pop_check("glitch_next", 8'hA3);
      check("glitch_next_count", 32'(fifo_count), 32'd0);

      // Framing error, clear, recovery
      send_byte(8'h3C, 1'b0);
      repeat (BIT_CLK) @(negedge clk);
      check("frame_err_set",   32'(frame_err),  32'd1);
      check("frame_err_count", 32'(fifo_count), 32'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
      check("frame_err_clr", 32'(frame_err), 32'd0);
      send_byte(8'h81, 1'b1);
      pop_check("frame_next", 8'h81);

      // Overrun: 17 bytes into a 16-entry FIFO
      for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
      @(negedge clk);
      check("ovr_count", 32'(fifo_count), 32'd16);
      check("ovr_flag",  32'(overrun),    32'd1);
      for (int i = 0; i < 16; i++) pop_check($sformatf("ovr_rd%0d", i), 8'(i));
      @(negedge clk);
      check("ovr_drained", 32'(data_valid), 32'd0);

      // Full FIFO with a pop coinciding with the next push
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
      check("ovr_clr", 32'(overrun), 32'd0);
      for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1);
      check("full_count", 32'(fifo_count), 32'd16);
      fork
         send_byte(8'h77, 1'b1);
         begin
            n = 0;
            while (!dut.push_c && n < 2000) begin
               @(negedge clk);
               n++;
            end
            check("full_push_seen", 32'(n < 2000), 32'd1);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
         end
      join
      check("full_rw_overrun", 32'(overrun),    32'd0);
      check("full_rw_count",   32'(fifo_count), 32'd16);
      for (int i = 1; i < 16; i++) pop_check($sformatf("full_rd%0d", i), 8'(8'h20 + i));
      pop_check("full_tail", 8'h77);

      // Reset during data bit 4 of 0xF0, with a byte queued and frame_err set
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      check("pre_rst_count", 32'(fifo_count), 32'd1);
      check("pre_rst_ferr",  32'(frame_err),  32'd1);
      fork
         send_byte(8'hF0, 1'b1);
         begin
            repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            check("midrst_valid",   32'(data_valid), 32'd0);
            check("midrst_count",   32'(fifo_count), 32'd0);
            check("midrst_ferr",    32'(frame_err),  32'd0);
            check("midrst_overrun", 32'(overrun),    32'd0);
         end
      join
      repeat (BIT_CLK) @(negedge clk);
      check("midrst_no_rx", 32'(fifo_count), 32'd0);
      send_byte(8'h5A, 1'b1);
      @(negedge clk);
      check("after_rst_count", 32'(fifo_count), 32'd1);
      check("after_rst_ferr",  32'(frame_err),  32'd0);
      pop_check("after_rst_data", 8'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Oversampling UART receiver with a small first-word-fall-through receive FIFO. It is the serial-input end of the 8N1 link used by the peripheral UART: it deserializes `rxd`, checks framing, and buffers bytes so the CPU-side bus logic can drain them without per-byte timing constraints. It sits between the `com_RxD` pin and the peripheral bus, and replaces the bare receiver when buffering and error reporting are needed.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate.
- `FIFO_DEPTH`, 16, receive FIFO entries; power of two, 2..256.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `rxd`  in  1  asynchronous serial input; idle high.
- `rd_en`  in  1  pop FIFO head this cycle.
- `data_out`  out  8  FIFO head byte; valid only while `data_valid`=1.
- `data_valid`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes held.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun`  out  1  sticky: a good byte arrived while FIFO full.
- `err_clr`  in  1  clears both sticky flags.

## Operation
- Input sync: `rxd` passes through two flops (reset value 1); all logic uses the synchronized `rxs`.
- Oversample tick: divider reloads at DIV = round(CLK_FREQ/(16*BAUD)) (27 at defaults); one-cycle `tick` on reload. Divider runs freely.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on `tick` with `rxs`=0 -> START, sample counter cleared.
  - START: at tick 8, `rxs`=1 -> IDLE (glitch rejected); else -> DATA, bit index 0, counter cleared.
  - DATA: per 16-tick bit cell, samples at ticks 7, 8, 9; bit value = majority. Shifted in LSB first. After bit 7 -> STOP.
  - STOP: majority at ticks 7..9. 1 -> push byte, -> IDLE. 0 -> set `frame_err`, byte discarded, -> BREAK.
  - BREAK: wait for `rxs`=1 on a tick -> IDLE.
- FIFO: circular buffer, write/read pointers one bit wider than the address; full = addresses equal and MSBs differ. Storage array is not reset.
- Push when full: byte dropped, `overrun` set, FIFO unchanged.
- `rd_en` when empty: ignored, no pointer change.
- Push and pop in the same cycle: full -> both happen, no overrun, count unchanged; empty -> push only; otherwise both, count unchanged.
- `err_clr` and a new error in the same cycle: the flag is set (set wins).
- `fifo_count` = wptr − rptr, modulo 2^(addr bits+1).

## Timing
- Reset values: `data_valid`=0, `fifo_count`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, pointers and counters 0. `data_out` is don't-care while `data_valid`=0.
- Reset asserted mid-frame: the frame is abandoned, the FIFO is emptied, and the FSM returns to IDLE. The line must be high for one tick before a new start is detected; a frame whose start edge precedes reset release is not received.
- Input latency: 2 `clk` cycles of synchronizer plus up to one tick of start detection.
- Byte latency: push occurs on the stop-bit tick 9. `data_valid`, `fifo_count`, and `data_out` update on the next `clk` edge, about 9.6 bit times after the start edge.
- First-word fall-through: `data_out` shows the head combinationally from the registered read pointer. After `rd_en` with `data_valid`=1, the next head appears on the following cycle.
- Sticky flags assert one cycle after the stop-bit decision and clear the cycle after `err_clr`.
- Baud tolerance: the receiver accepts ±3% rate mismatch over the 10-bit frame.

## Test plan
- Single byte: send 0x55 at 115200 with `rd_en`=0 -> `data_valid`=1, `data_out`=0x55, `fifo_count`=1; then pulse `rd_en` one cycle -> `data_valid`=0, `fifo_count`=0.
- Glitch: drive `rxd` low for 2 µs, then high -> no push, FSM back in IDLE, `fifo_count` stays 0. A following 0xA3 frame is received correctly.
- Framing: send 0x3C with the stop bit low, then release the line -> `frame_err`=1, `fifo_count`=0. `err_clr` -> `frame_err`=0. The next 0x81 is received.
- Overrun: send 17 bytes 0x00..0x10 with no reads -> `fifo_count`=16, `overrun`=1. The 16 reads return 0x00..0x0F in order.
- Full plus simultaneous read: with the FIFO full, hold `rd_en` high for one cycle aligned to the next push -> `overrun`=0, `fifo_count`=16, and the new byte ends up at the tail.
- Reset mid-frame: assert `rst` during data bit 4 of 0xF0 -> all outputs at reset values. The next frame 0x5A is received and `frame_err`=0.
